// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, FSM encoding
// and the opcode legality check.
package alu_pkg;

   // ALU opcodes understood by ALU_8_bit
   localparam logic [3:0] OP_ADD = 4'b1111;
   localparam logic [3:0] OP_SUB = 4'b1110;
   localparam logic [3:0] OP_AND = 4'b0111;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_NOT = 4'b0100;

   // Controller FSM encoding
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ISSUE  = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   // True when the ALU implements the given opcode
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_NOT);
   endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Combinational two-way round-robin arbiter. The pointer names the
// requester that wins a tie; a lone requester always wins.
module alu_rr_arb2
(
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] grant
);

   // Pick the winner; grant is one-hot or zero
   // NOTE: every path assigns grant, so no latch is inferred.
   always_comb begin
      grant = 2'b00;
      if (valid == 2'b11)
         grant = ptr ? 2'b10 : 2'b01;
      else
         grant = valid;
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters: round-robin accept,
// operand latch, two-cycle ALU enable, result capture and per-requester
// valid/ready response.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int W = 8
)
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [2*W-1:0] req_a,
   input  logic [2*W-1:0] req_b,
   input  logic [7:0]     req_op,
   output logic [1:0]     rsp_valid,
   input  logic [1:0]     rsp_ready,
   output logic [W-1:0]   rsp_out,
   output logic           rsp_cout,
   output logic           rsp_err,
   output logic           alu_en,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic [3:0]     alu_op,
   input  logic [W-1:0]   alu_out,
   input  logic           alu_cout
);

   logic [1:0]   r_state;
   logic         r_ptr;
   logic         r_id;
   logic [W-1:0] r_a;
   logic [W-1:0] r_b;
   logic [3:0]   r_op;
   logic [W-1:0] r_out;
   logic         r_cout;
   logic         r_err;

   logic [1:0]   w_grant;
   logic         w_accept;
   logic         w_win;
   logic [W-1:0] w_a;
   logic [W-1:0] w_b;
   logic [3:0]   w_op;

   alu_rr_arb2 u_arb (
      .valid (req_valid),
      .ptr   (r_ptr),
      .grant (w_grant)
   );

   // Offer ready only in IDLE and select the winner's command fields
   always_comb begin
      req_ready = (r_state == IDLE) ? w_grant : 2'b00;
      w_accept  = |(req_valid & req_ready);
      w_win     = w_grant[1];
      w_a       = w_win ? req_a[2*W-1:W] : req_a[W-1:0];
      w_b       = w_win ? req_b[2*W-1:W] : req_b[W-1:0];
      w_op      = w_win ? req_op[7:4]    : req_op[3:0];
   end

   // Sequence accept -> ISSUE -> SAMPLE -> RESP and hold the latched command
   // NOTE: state uses non-blocking assignments so every register samples
   // pre-edge values; the async reset clears state and outputs immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= 1'b0;
         r_id    <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= 4'b0000;
         r_out   <= '0;
         r_cout  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a   <= w_a;
                  r_b   <= w_b;
                  r_op  <= w_op;
                  r_id  <= w_win;
                  r_ptr <= ~w_win;
                  if (is_legal_op(w_op)) begin
                     r_state <= ISSUE;
                  end else begin
                     r_out   <= '0;
                     r_cout  <= 1'b0;
                     r_err   <= 1'b1;
                     r_state <= RESP;
                  end
               end
            end
            ISSUE: r_state <= SAMPLE;
            SAMPLE: begin
               r_out   <= alu_out;
               r_cout  <= alu_cout;
               r_err   <= 1'b0;
               r_state <= RESP;
            end
            RESP: begin
               if (rsp_ready[r_id])
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Drive ALU and response outputs straight from the registers
   always_comb begin
      alu_en    = (r_state == ISSUE) || (r_state == SAMPLE);
      alu_a     = r_a;
      alu_b     = r_b;
      alu_op    = r_op;
      rsp_valid = (r_state == RESP) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
      rsp_out   = r_out;
      rsp_cout  = r_cout;
      rsp_err   = r_err;
   end

endmodule
